// File: rtl/sobel_mag_if.sv
// sobel_mag_if: gradient-in / magnitude-out stream bundle for sobel_mag
//   valid_i/ready_o/gx_i/gy_i/mode_i/thresh_i : input pair handshake and per-pixel controls
//   valid_o/ready_i/data_o/last_o             : output pixel handshake, pixel and end-of-frame flag
//   master drives the input pair and consumes pixels; slave is the magnitude block
interface sobel_mag_if #(parameter int WIDTH_P = 8);
  logic                        valid_i;
  logic                        ready_o;
  logic signed [2*WIDTH_P-1:0] gx_i;
  logic signed [2*WIDTH_P-1:0] gy_i;
  logic [1:0]                  mode_i;
  logic [WIDTH_P-1:0]          thresh_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [WIDTH_P-1:0]          data_o;
  logic                        last_o;
  modport master(output valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
                 input ready_o, valid_o, data_o, last_o);
  modport slave(input valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
                output ready_o, valid_o, data_o, last_o);
endinterface

// File: rtl/sobel_mag.sv
// sobel_mag: 2-stage gradient magnitude pipeline with saturation, threshold and frame position tracking
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset
//   bus    : sobel_mag_if slave (input gradient pair in, magnitude pixel out)
//   SOBEL_MAG_BORDER_EN : when defined, pixels on the frame border output 0
module sobel_mag #(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input logic        clk_i,
  input logic        rstn_i,
  sobel_mag_if.slave bus
);
  localparam int GW = 2 * WIDTH_P;
  localparam int CW = $clog2(LINE_W_P);
  localparam int RW = $clog2(FRAME_H_P);
  logic               s1_v, s1_bd, s1_last;
  logic [GW-1:0]      s1_ax, s1_ay;
  logic [1:0]         s1_mode;
  logic [WIDTH_P-1:0] s1_th;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [GW-1:0]      ax, ay;
  logic [GW:0]        mag;
  logic [WIDTH_P-1:0] sat, pix;
  logic               s2_load, in_xfer, at_eol, at_eof, border;
  assign s2_load     = !bus.valid_o || bus.ready_i;
  assign bus.ready_o = !s1_v || s2_load;
  assign in_xfer     = bus.valid_i && bus.ready_o;
  // two's-complement negate as unsigned, so the most negative value maps to 2^(GW-1)
  assign ax     = bus.gx_i[GW-1] ? ~bus.gx_i + 1'b1 : bus.gx_i;
  assign ay     = bus.gy_i[GW-1] ? ~bus.gy_i + 1'b1 : bus.gy_i;
  assign at_eol = col == CW'(LINE_W_P - 1);
  assign at_eof = row == RW'(FRAME_H_P - 1);
`ifdef SOBEL_MAG_BORDER_EN
  assign border = col == '0 || at_eol || row == '0 || at_eof;
`else
  assign border = 1'b0;
`endif
  always_comb begin
    mag = s1_mode == 2'd0 ? {1'b0, s1_ax} :
          s1_mode == 2'd1 ? {1'b0, s1_ay} :
          s1_mode == 2'd2 ? {1'b0, s1_ax} + {1'b0, s1_ay} :
          s1_ax > s1_ay   ? {1'b0, s1_ax} : {1'b0, s1_ay};
    sat = |mag[GW:WIDTH_P] ? '1 : mag[WIDTH_P-1:0];
    pix = s1_bd ? '0 : s1_th == '0 ? sat : sat >= s1_th ? '1 : '0;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      col <= at_eol ? '0 : col + 1'b1;
      row <= !at_eol ? row : at_eof ? '0 : row + 1'b1;
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      s1_v    <= 1'b0;
      s1_ax   <= '0;
      s1_ay   <= '0;
      s1_mode <= '0;
      s1_th   <= '0;
      s1_bd   <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      if (bus.ready_o) s1_v <= bus.valid_i;
      if (in_xfer) begin
        s1_ax   <= ax;
        s1_ay   <= ay;
        s1_mode <= bus.mode_i;
        s1_th   <= bus.thresh_i;
        s1_bd   <= border;
        s1_last <= at_eol && at_eof;
      end
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.last_o  <= 1'b0;
    end else if (s2_load) begin
      bus.valid_o <= s1_v;
      if (s1_v) begin
        bus.data_o <= pix;
        bus.last_o <= s1_last;
      end
    end
endmodule

// File: doc/sobel_mag.md
SOBEL_MAG -- requirements
Module: sobel_mag

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 Parameter WIDTH_P, default 8, SHALL set the output pixel width; gradient inputs are 2*WIDTH_P bits.
REQ-003 Parameter LINE_W_P, default 640, SHALL set the pixels per line (at least 3).
REQ-004 Parameter FRAME_H_P, default 480, SHALL set the lines per frame (at least 3).
REQ-005 The block SHALL have these ports:
- clk_i, input, 1: clock.
- rstn_i, input, 1: asynchronous active-low reset.
- valid_i, input, 1: gradient pair valid.
- ready_o, output, 1: block accepts the input pair.
- gx_i, input, 2*WIDTH_P, signed: horizontal gradient.
- gy_i, input, 2*WIDTH_P, signed: vertical gradient.
- mode_i, input, 2: magnitude mode.
- thresh_i, input, WIDTH_P: binarisation threshold; 0 disables it.
- valid_o, output, 1: output pixel valid.
- ready_i, input, 1: downstream accepts the output pixel.
- data_o, output, WIDTH_P: magnitude pixel.
- last_o, output, 1: final pixel of the frame.

Function
REQ-006 An input transfer SHALL occur when valid_i and ready_o are both high; an output transfer SHALL occur when valid_o and ready_i are both high.
REQ-007 The datapath SHALL be a 2-stage registered pipeline:
- S1 registers |gx| and |gy| as unsigned 2*WIDTH_P-bit values, plus the mode, threshold, border flag and last flag.
- S2 registers data_o and last_o.
REQ-008 A stage SHALL load when it is empty or its contents transfer in the same cycle.
REQ-009 ready_o SHALL equal (S1 empty) OR (S1 can advance).
REQ-010 With no backpressure, latency SHALL be 2 cycles and throughput 1 pixel per cycle.
REQ-011 Data SHALL be neither dropped nor duplicated, and order SHALL be preserved.
REQ-012 While valid_o is high and ready_i is low, data_o and last_o SHALL hold stable.
REQ-013 The absolute value of -2^(2*WIDTH_P-1) SHALL be 2^(2*WIDTH_P-1), with no wrap.
REQ-014 mode_i SHALL select the magnitude:
- 0: |gx|
- 1: |gy|
- 2: |gx| + |gy|, computed at 2*WIDTH_P+1 bits
- 3: max(|gx|, |gy|)
REQ-015 The magnitude SHALL saturate to 2^WIDTH_P-1 when it exceeds that value.
REQ-016 If the captured threshold is nonzero, data_o SHALL be all-ones when the saturated magnitude is at least the threshold, and 0 otherwise.
REQ-017 mode_i and thresh_i SHALL be sampled per pixel at input transfer, so a mid-stream change affects only later pixels.
REQ-018 Column counter col (0..LINE_W_P-1) and row counter row (0..FRAME_H_P-1) SHALL advance on each input transfer.
REQ-019 col SHALL wrap to 0 and increment row; row SHALL wrap to 0 after the last line.
REQ-020 last_o SHALL be high only on the output pixel captured at col=LINE_W_P-1 and row=FRAME_H_P-1.

Reset
REQ-021 Asserting rstn_i SHALL immediately clear: valid_o=0, data_o=0, last_o=0, both stage-valid flags, col=0, row=0.
REQ-022 ready_o SHALL be 1 during reset.
REQ-023 A reset mid-frame SHALL discard in-flight pixels; the next accepted pixel after reset SHALL be col=0, row=0.

Configuration
REQ-024 Macro SOBEL_MAG_BORDER_EN defined: pixels captured at col=0, col=LINE_W_P-1, row=0 or row=FRAME_H_P-1 SHALL output data_o=0, regardless of mode and threshold.
REQ-025 With the macro defined, latency, handshake and last_o SHALL be unchanged.
REQ-026 Macro SOBEL_MAG_BORDER_EN undefined: border pixels SHALL output their computed value; the counters and last_o remain.

Verification
REQ-027 Arithmetic (WIDTH_P=8, ready_i=1): mode 2, thresh 0, gx=-100, gy=50 -> data_o=150, valid_o 2 cycles after acceptance.
REQ-028 Saturation: mode 2, gx=200, gy=-100 -> 255; mode 0, gx=-32768 -> 255; mode 1, gy=-3 -> 3.
REQ-029 Threshold: mode 3, thresh 60: gx=10, gy=-70 -> 255; gx=10, gy=59 -> 0; then thresh 0 on the next pixel -> 59.
REQ-030 Backpressure: ready_i=0 for 6 cycles while 4 pixels are offered -> exactly 2 accepted, then ready_o=0 with data_o stable; on release all 4 emerge in order with no loss.
REQ-031 Frame (LINE_W_P=4, FRAME_H_P=3, mode 0, gx=20, 13 pixels) with SOBEL_MAG_BORDER_EN:
- only pixels 6 and 7 (row 1, col 1-2) output 20; all others output 0.
- last_o is high only on pixel 12.
- pixel 13 is a border pixel (col 0, row 0) -> 0.
REQ-032 The REQ-031 stimulus without SOBEL_MAG_BORDER_EN -> all pixels output 20, and last_o is still high on pixel 12.
REQ-033 Reset after 5 accepted pixels -> valid_o=0 immediately; after release, pixel 12 after reset carries last_o.
